// File: rtl/char_slot_scheduler.sv
// rtl/char_slot_scheduler.sv - falling-character slot table with move/match/spawn scan FSM
// One event per pass from IDLE; every pass scans the whole table one slot per cycle.
module char_slot_scheduler #(
  parameter int SLOTS       = 16,
  parameter int IDX_W       = 4,
  parameter int LOWER_BOUND = 480,
  parameter int MAX_MISS    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spawn_req,
  input  logic [7:0]       spawn_ascii,
  input  logic [9:0]       spawn_col,
  input  logic [9:0]       spawn_y,
  input  logic [2:0]       spawn_speed,
  output logic             spawn_ack,
  output logic             spawn_drop,
  input  logic             tick,
  input  logic             key_valid,
  input  logic [7:0]       key_ascii,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [9:0]       rd_col,
  output logic [9:0]       rd_y,
  output logic [7:0]       rd_ascii,
  output logic [15:0]      score,
  output logic [7:0]       miss_cnt,
  output logic             gameover,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_MATCH, S_REMOVE, S_SPAWN, S_ACK} state_t;
  state_t state_q, state_d;

  logic [SLOTS-1:0] active_q, active_d;
  logic [9:0]       col_q   [SLOTS];
  logic [9:0]       col_d   [SLOTS];
  logic [9:0]       y_q     [SLOTS];
  logic [9:0]       y_d     [SLOTS];
  logic [7:0]       ascii_q [SLOTS];
  logic [7:0]       ascii_d [SLOTS];
  logic [2:0]       speed_q [SLOTS];
  logic [2:0]       speed_d [SLOTS];

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             best_found_q, best_found_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [9:0]       best_y_q, best_y_d;
  logic             free_found_q, free_found_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;
  logic             collide_q, collide_d;
  logic             tick_pend_q, tick_pend_d;
  logic             key_pend_q, key_pend_d;
  logic [7:0]       key_ascii_q, key_ascii_d;
  logic [7:0]       match_key_q, match_key_d;
  logic [15:0]      score_q, score_d;
  logic [7:0]       miss_q, miss_d;
  logic             gameover_q, gameover_d;
  logic             rd_valid_q;
  logic [9:0]       rd_col_q, rd_y_q;
  logic [7:0]       rd_ascii_q;

  logic        last;
  logic        reject;
  logic [10:0] sum;

  assign last   = &idx_q;
  assign reject = gameover_q | ~free_found_q | collide_q;
  assign sum    = {1'b0, y_q[idx_q]} + {8'd0, speed_q[idx_q]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Raw strobes take part in dispatch so simultaneous events keep tick > key > spawn order
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!gameover_q && (tick_pend_q || tick))           state_d = S_MOVE;
        else if (!gameover_q && (key_pend_q || key_valid))  state_d = S_MATCH;
        else if (spawn_req)                                 state_d = S_SPAWN;
      end
      S_MOVE:   if (last) state_d = S_IDLE;
      S_MATCH:  if (last) state_d = S_REMOVE;
      S_REMOVE: state_d = S_IDLE;
      S_SPAWN:  if (last) state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    spawn_ack  = (state_q == S_ACK);
    spawn_drop = (state_q == S_ACK) && reject;
  end

  always_comb begin
    active_d     = active_q;
    col_d        = col_q;
    y_d          = y_q;
    ascii_d      = ascii_q;
    speed_d      = speed_q;
    score_d      = score_q;
    miss_d       = miss_q;
    gameover_d   = gameover_q;
    idx_d        = (state_q == S_IDLE) ? '0 : idx_q + IDX_W'(1);
    best_found_d = best_found_q;
    best_idx_d   = best_idx_q;
    best_y_d     = best_y_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    collide_d    = collide_q;
    case (state_q)
      S_IDLE: begin
        best_found_d = 1'b0;
        best_idx_d   = '0;
        best_y_d     = '0;
        free_found_d = 1'b0;
        free_idx_d   = '0;
        collide_d    = 1'b0;
      end
      S_MOVE: begin
        if (active_q[idx_q] && !gameover_q) begin
          if (sum >= 11'(LOWER_BOUND)) begin
            active_d[idx_q] = 1'b0;
            if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
          end else begin
            y_d[idx_q] = sum[9:0];
          end
        end
      end
      S_MATCH: begin
        // Strict greater-than keeps the lower index on equal y
        if (active_q[idx_q] && ascii_q[idx_q] == match_key_q &&
            (!best_found_q || y_q[idx_q] > best_y_q)) begin
          best_found_d = 1'b1;
          best_idx_d   = idx_q;
          best_y_d     = y_q[idx_q];
        end
      end
      S_REMOVE: begin
        if (best_found_q && !gameover_q) begin
          active_d[best_idx_q] = 1'b0;
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        end
      end
      S_SPAWN: begin
        if (!active_q[idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (active_q[idx_q] && col_q[idx_q] == spawn_col) collide_d = 1'b1;
      end
      S_ACK: begin
        if (!reject) begin
          active_d[free_idx_q] = 1'b1;
          col_d[free_idx_q]    = spawn_col;
          y_d[free_idx_q]      = spawn_y;
          ascii_d[free_idx_q]  = spawn_ascii;
          speed_d[free_idx_q]  = spawn_speed;
        end
      end
      default: ;
    endcase
    if (miss_d >= 8'(MAX_MISS)) gameover_d = 1'b1;
  end

  always_comb begin
    key_ascii_d = key_valid ? key_ascii : key_ascii_q;
    tick_pend_d = (tick_pend_q | tick) & ~(state_q == S_IDLE && state_d == S_MOVE) & ~gameover_q;
    key_pend_d  = (key_pend_q | key_valid) & ~(state_q == S_IDLE && state_d == S_MATCH) & ~gameover_q;
    match_key_d = match_key_q;
    if (state_q == S_IDLE && state_d == S_MATCH) match_key_d = key_ascii_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      active_q     <= '0;
      best_found_q <= 1'b0;
      best_idx_q   <= '0;
      best_y_q     <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      collide_q    <= 1'b0;
      tick_pend_q  <= 1'b0;
      key_pend_q   <= 1'b0;
      key_ascii_q  <= '0;
      match_key_q  <= '0;
      score_q      <= '0;
      miss_q       <= '0;
      gameover_q   <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      active_q     <= active_d;
      best_found_q <= best_found_d;
      best_idx_q   <= best_idx_d;
      best_y_q     <= best_y_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      collide_q    <= collide_d;
      tick_pend_q  <= tick_pend_d;
      key_pend_q   <= key_pend_d;
      key_ascii_q  <= key_ascii_d;
      match_key_q  <= match_key_d;
      score_q      <= score_d;
      miss_q       <= miss_d;
      gameover_q   <= gameover_d;
    end
  end

  always_ff @(posedge clk) begin
    col_q   <= col_d;
    y_q     <= y_d;
    ascii_q <= ascii_d;
    speed_q <= speed_d;
  end

  // Data fields only follow active slots so the render path keeps its last image
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_col_q   <= '0;
      rd_y_q     <= '0;
      rd_ascii_q <= '0;
    end else begin
      rd_valid_q <= active_q[rd_idx];
      if (active_q[rd_idx]) begin
        rd_col_q   <= col_q[rd_idx];
        rd_y_q     <= y_q[rd_idx];
        rd_ascii_q <= ascii_q[rd_idx];
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_col   = rd_col_q;
  assign rd_y     = rd_y_q;
  assign rd_ascii = rd_ascii_q;
  assign score    = score_q;
  assign miss_cnt = miss_q;
  assign gameover = gameover_q;

endmodule

// File: doc/char_slot_scheduler.md
Name: char_slot_scheduler

Overview:
- Central scheduler for the falling-character game; owns a fixed table of active character slots (column, vertical offset, speed, ASCII code).
- Sequences three events on the table: spawn requests from the random generator, periodic move ticks, and keypress removals.
- Detects characters crossing the bottom bound, and maintains score, miss count and the sticky game-over flag.
- The VGA render path reads slot state through a registered read port.

Parameters:
SLOTS, 16, number of character slots (power of 2, 4..64)
IDX_W, 4, slot index width, equal to log2(SLOTS)
LOWER_BOUND, 480, a y offset at or above this value is a miss
MAX_MISS, 8, miss count that asserts gameover

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
spawn_req  in  1  level; held by the requester until spawn_ack
spawn_ascii  in  8  character to place
spawn_col  in  10  column (x pixel) of new character
spawn_y  in  10  initial y offset
spawn_speed  in  3  pixels per tick
spawn_ack  out  1  one-cycle pulse; request consumed
spawn_drop  out  1  valid with spawn_ack; request rejected
tick  in  1  one-cycle move strobe
key_valid  in  1  one-cycle strobe; new key pressed
key_ascii  in  8  ASCII of the pressed key
rd_idx  in  IDX_W  slot to read
rd_valid  out  1  slot active (1-cycle read latency)
rd_col  out  10  slot column
rd_y  out  10  slot y offset
rd_ascii  out  8  slot character
score  out  16  removed-character count, saturates at 16'hFFFF
miss_cnt  out  8  missed-character count, saturates at 8'hFF
gameover  out  1  sticky until rst
busy  out  1  FSM is not in IDLE

Behaviour:
- Reset:
  - Takes effect on the clock edge, including mid-scan.
  - All slots become inactive; FSM returns to IDLE.
  - score, miss_cnt, gameover, spawn_ack, spawn_drop, busy and the rd_* outputs all read 0.
  - Pending flags are cleared.
- Event capture:
  - tick and key_valid are latched into tick_pend and key_pend (key_ascii is latched with key_pend) in any state.
  - A repeat of an event while its flag is already pending is coalesced; for keys, the latest key_ascii wins.
  - spawn_req is sampled only while in IDLE.
- Dispatch from IDLE, one event per entry, fixed priority: tick_pend > key_pend > spawn_req. The chosen pending flag clears on entry to its state.
- MOVE:
  - Visits slots 0..SLOTS-1, one per cycle (SLOTS cycles).
  - For an active slot, compute sum = y + speed as 11 bits.
  - If sum >= LOWER_BOUND: the slot becomes inactive and miss_cnt increments.
  - Otherwise y <= sum[9:0].
  - speed 0 is legal; the slot never moves.
- MATCH:
  - Visits all slots (SLOTS cycles), tracking the best candidate: active, ascii == latched key, largest y. Ties go to the lower index.
  - Then REMOVE (1 cycle): if a candidate exists, that slot becomes inactive and score increments; otherwise there is no state change.
- SPAWN:
  - Visits all slots (SLOTS cycles), finding the lowest-index free slot and any active slot whose col == spawn_col.
  - Then ACK (1 cycle): spawn_ack = 1.
  - If there is no free slot or there is a column collision: spawn_drop = 1 and the table is unchanged.
  - Otherwise the free slot is loaded and made active.
- gameover:
  - Set in the cycle miss_cnt reaches MAX_MISS.
  - While gameover = 1:
    - ticks and keys are discarded;
    - spawns are acked with spawn_drop = 1;
    - the table is frozen.
- Read port:
  - rd_* are registered from slot rd_idx; latency is 1 cycle.
  - Reads of a slot being written in the same cycle return the old value.
  - rd_col, rd_y and rd_ascii hold their last contents when rd_valid = 0.
- busy is 0 only in IDLE.
- Worst-case event latency: 3*(SLOTS+1)+1 cycles.

Test Plan:
- Spawn (ascii 8'h41, col 100, y 0, speed 3), then 2 ticks -> rd_idx 0 shows valid = 1, col 100, y 6; spawn_ack pulses once; spawn_drop = 0.
- Fill all 16 slots, then a 17th spawn -> spawn_ack with spawn_drop = 1. A separate spawn on an occupied column -> spawn_drop = 1.
- Slots A at y 40 and A at y 200 plus slot B; key 8'h41 -> the y-200 slot is cleared, score = 1. Then key 8'h5A -> no change.
- Slot at y 478, speed 3, tick -> slot inactive, miss_cnt = 1. After 8 misses -> gameover = 1. Later keys and ticks leave score and the table unchanged.
- tick, key_valid and spawn_req all in the same cycle -> MOVE runs, then MATCH, then SPAWN. Two ticks during MOVE -> exactly one extra MOVE pass.
- Assert rst mid-MATCH -> next cycle busy = 0, every slot reads rd_valid = 0, score = 0.
